// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of ALU and load results onto the single
// register-file write port, plus a pending scoreboard that flags read-after-write hazards.
module regfile_wb_scheduler #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [SEL_W-1:0]  rsv_sel,
    input  logic [SEL_W-1:0]  chk_sel1,
    input  logic [SEL_W-1:0]  chk_sel2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              rf_write,
    output logic [SEL_W-1:0]  rf_sel_w,
    output logic [DATA_W-1:0] rf_data,
    output logic [NREGS-1:0]  pending,
    output logic              rsv_err
);

    // Handshake: a request transfers on a posedge where reqN_valid && reqN_ready are both
    // high; ready is combinational and at most one requester is ready in any cycle.
    logic              last_grant_q, last_grant_d;
    logic              rf_write_q, rf_write_d;
    logic [SEL_W-1:0]  rf_sel_w_q, rf_sel_w_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREGS-1:0]  pending_q, pending_d;
    logic              rsv_err_q, rsv_err_d;
    logic              grant0, grant1;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);

        last_grant_d = last_grant_q;
        rf_write_d   = 1'b0;
        rf_sel_w_d   = rf_sel_w_q;
        rf_data_d    = rf_data_q;
        if (grant0) begin
            last_grant_d = 1'b0;
            rf_write_d   = (req0_sel != '0);
            rf_sel_w_d   = req0_sel;
            rf_data_d    = req0_data;
        end else if (grant1) begin
            last_grant_d = 1'b1;
            rf_write_d   = (req1_sel != '0);
            rf_sel_w_d   = req1_sel;
            rf_data_d    = req1_data;
        end
    end

    // Clear is applied before reserve so a same-edge reserve of the retiring register wins
    // and does not count as a double reservation.
    always_comb begin
        pending_d = pending_q;
        rsv_err_d = rsv_err_q;
        if (rf_write_q) begin
            pending_d[rf_sel_w_q] = 1'b0;
        end
        if (rsv_valid && (rsv_sel != '0)) begin
            if (pending_d[rsv_sel]) begin
                rsv_err_d = 1'b1;
            end
            pending_d[rsv_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rf_write_q   <= 1'b0;
            rf_sel_w_q   <= '0;
            rf_data_q    <= '0;
            pending_q    <= '0;
            rsv_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_write_q   <= rf_write_d;
            rf_sel_w_q   <= rf_sel_w_d;
            rf_data_q    <= rf_data_d;
            pending_q    <= pending_d;
            rsv_err_q    <= rsv_err_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign hazard1    = (chk_sel1 != '0) && pending_q[chk_sel1];
    assign hazard2    = (chk_sel2 != '0) && pending_q[chk_sel2];
    assign rf_write   = rf_write_q;
    assign rf_sel_w   = rf_sel_w_q;
    assign rf_data    = rf_data_q;
    assign pending    = pending_q;
    assign rsv_err    = rsv_err_q;

endmodule
